// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial LSB-first adder built around a single full-adder cell

// One-bit full-adder cell shared by every bit position of the serial adder.
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (C & (A ^ B));

endmodule

// Adds OpA + OpB + CarryIn one bit per clock, LSB first, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [WIDTH-1:0] sh_s;
  logic             cy;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_carry;

  // The cell always sees the current LSBs of both operand shifters and the stored carry.
  FullAdder u_fa (
    .A    (sh_a[0]),
    .B    (sh_b[0]),
    .C    (cy),
    .Sum  (fa_sum),
    .Carry(fa_carry)
  );

  // Control FSM and datapath: load on Start, shift WIDTH times, publish the result on the last bit.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      sh_s     <= '0;
      cy       <= 1'b0;
      cnt      <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Sum      <= '0;
      CarryOut <= 1'b0;
    end else begin
      case (state)
        // DONE behaves like IDLE for Start so back-to-back additions need no idle gap.
        IDLE, DONE: begin
          Done <= 1'b0;
          if (Start) begin
            sh_a  <= OpA;
            sh_b  <= OpB;
            cy    <= CarryIn;
            cnt   <= '0;
            Busy  <= 1'b1;
            state <= RUN;
          end else begin
            Busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sh_s <= {fa_sum, sh_s[WIDTH-1:1]};
          cy   <= fa_carry;
          sh_a <= {1'b0, sh_a[WIDTH-1:1]};
          sh_b <= {1'b0, sh_b[WIDTH-1:1]};
          cnt  <= cnt + 1'b1;
          if (cnt == LAST_BIT) begin
            // The final sum bit is still in flight, so publish it straight from the cell.
            Sum      <= {fa_sum, sh_s[WIDTH-1:1]};
            CarryOut <= fa_carry;
            Busy     <= 1'b0;
            Done     <= 1'b1;
            state    <= DONE;
          end else begin
            Busy <= 1'b1;
            Done <= 1'b0;
          end
        end
        default: begin
          Busy  <= 1'b0;
          Done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
